// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared frame constants, word field map and readback FSM states
package pattern_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hFA;
    localparam logic [7:0] END_BYTE    = 8'hFF;
    localparam logic [7:0] CMD_TRIGGER = 8'd25;
    localparam logic [7:0] CMD_STOP    = 8'd26;

    localparam int DUR_MSB = 63;
    localparam int DUR_LSB = 32;
    localparam int PAT_MSB = 31;
    localparam int PAT_LSB = 16;
    localparam int LED_MSB = 7;
    localparam int LED_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_WORD,
        ST_TRAILER,
        ST_DONE
    } tx_state_e;

    // Word count actually dumped: requested length capped at the BRAM depth.
    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int addr_w);
        logic [16:0] cap;
        cap = 17'd1 << addr_w;
        if ({1'b0, len} > cap) return cap[15:0];
        return len;
    endfunction

endpackage

// File: rtl/pattern_readback_tx_if.sv
// rtl/pattern_readback_tx_if.sv - host/BRAM/line signals of the readback transmitter
interface pattern_readback_tx_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [15:0]       data_length;
    logic [ADDR_W-1:0] mem_ad;
    logic [63:0]       mem_dout;
    logic              busy;
    logic              done;
    logic              tx;

    modport master (
        output start, data_length, mem_dout,
        input  mem_ad, busy, done, tx
    );

    modport slave (
        input  start, data_length, mem_dout,
        output mem_ad, busy, done, tx
    );
endinterface

// File: rtl/pattern_readback_tx_uart_tx_byte.sv
// rtl/pattern_readback_tx_uart_tx_byte.sv - 8N1 byte serialiser with load/ready handshake
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk100,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          active;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic [8:0]    sh;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(DIV - 1));
    // Ready already in the stop bit's last cycle so the next start bit follows with no gap.
    assign ready   = !active || (bit_end && (bit_cnt == 4'd9));

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            sh       <= '0;
            tx       <= 1'b1;
        end else if (load && ready) begin
            active   <= 1'b1;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            sh       <= {1'b1, data};
            tx       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= sh[0];
                    sh      <= {1'b1, sh[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pattern_readback_tx.sv
// rtl/pattern_readback_tx.sv - dumps pattern BRAM words to the host as an FA/len/words/FF UART frame
import pattern_pkg::*;

module pattern_readback_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic                  clk100,
    input  logic                  rst_n,
    pattern_readback_tx_if.slave  bus
);
    localparam int         DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [7:0] RD_ARM = 8'(RD_LAT + 1);

    tx_state_e         state;
    logic              load_r;
    logic [7:0]        data_r;
    logic              ready;
    logic              tx_w;
    logic              accept;
    logic              busy_r;
    logic              done_r;
    logic              trl_sent;
    logic [ADDR_W-1:0] mem_ad_r;
    logic [15:0]       n_len;
    logic [15:0]       word_cnt;
    logic [2:0]        byte_idx;
    logic [63:0]       shreg;
    logic [7:0]        rd_wait;

    assign accept = load_r && ready;

    uart_tx_byte #(.DIV(DIV)) u_byte (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .load   (load_r),
        .data   (data_r),
        .ready  (ready),
        .tx     (tx_w)
    );

    // data_r holds the byte on offer; shreg holds the rest of the current word, or the
    // next word once its read has landed, so the prefetch never disturbs the pending byte.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            load_r   <= 1'b0;
            data_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            trl_sent <= 1'b0;
            mem_ad_r <= '0;
            n_len    <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            rd_wait  <= '0;
        end else begin
            if (rd_wait != 8'd0) rd_wait <= rd_wait - 8'd1;

            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= ST_HDR;
                        busy_r <= 1'b1;
                        load_r <= 1'b1;
                        data_r <= HDR_BYTE;
                        n_len  <= clamp_len(bus.data_length, ADDR_W);
                    end
                end
                ST_HDR: if (accept) begin
                    state  <= ST_LEN_HI;
                    data_r <= n_len[15:8];
                end
                ST_LEN_HI: if (accept) begin
                    state    <= ST_LEN_LO;
                    data_r   <= n_len[7:0];
                    mem_ad_r <= '0;
                    if (n_len != 16'd0) rd_wait <= RD_ARM;
                end
                ST_LEN_LO: if (accept) begin
                    if (n_len == 16'd0) begin
                        state  <= ST_TRAILER;
                        data_r <= END_BYTE;
                    end else begin
                        state    <= ST_WORD;
                        data_r   <= shreg[63:56];
                        shreg    <= {shreg[55:0], 8'h00};
                        byte_idx <= 3'd7;
                        word_cnt <= '0;
                    end
                end
                ST_WORD: if (accept) begin
                    if (byte_idx == 3'd0) begin
                        if (word_cnt == n_len - 16'd1) begin
                            state  <= ST_TRAILER;
                            data_r <= END_BYTE;
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                            byte_idx <= 3'd7;
                            data_r   <= shreg[63:56];
                            shreg    <= {shreg[55:0], 8'h00};
                        end
                    end else begin
                        byte_idx <= byte_idx - 3'd1;
                        data_r   <= shreg[63:56];
                        shreg    <= {shreg[55:0], 8'h00};
                        if (byte_idx == 3'd1) begin
                            mem_ad_r <= ADDR_W'(word_cnt + 16'd1);
                            rd_wait  <= RD_ARM;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (!trl_sent) begin
                        if (accept) begin
                            load_r   <= 1'b0;
                            trl_sent <= 1'b1;
                        end
                    end else if (ready) begin
                        state    <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        trl_sent <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Read data is stable one cycle after the BRAM latency has elapsed.
            if (rd_wait == 8'd1) shreg <= bus.mem_dout;
        end
    end

    assign bus.mem_ad = mem_ad_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.tx     = tx_w;
endmodule

// File: tb/tb_pattern_readback_tx.sv
// tb/tb_pattern_readback_tx.sv - table-driven frame checks plus DONE-cycle and mid-frame reset sequences
module tb_pattern_readback_tx;
    localparam int CLK_HZ   = 100_000_000;
    localparam int BAUD     = 12_500_000;
    localparam int DIV      = 8;
    localparam int BYTE_CYC = 10 * DIV;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int RD_LAT   = 2;

    logic clk100 = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;

    pattern_readback_tx_if #(.ADDR_W(ADDR_W)) bus ();

    pattern_readback_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc <= cyc + 1;

    // Two-stage BRAM read pipeline
    logic [63:0] mem [DEPTH];
    logic [63:0] p0, p1;
    always @(posedge clk100) begin
        p0 <= mem[bus.mem_ad];
        p1 <= p0;
    end
    assign bus.mem_dout = p1;

    // UART line decoder: mid-bit sampling, start cycle recorded per byte
    logic [7:0] mon_bytes[$];
    int         mon_starts[$];
    int         mon_ferr = 0;
    initial begin
        forever begin
            @(negedge clk100);
            if (rst_n && bus.tx === 1'b0) begin
                int         t0;
                logic [7:0] b;
                t0 = cyc;
                repeat (DIV / 2) @(negedge clk100);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk100);
                    b[i] = bus.tx;
                end
                repeat (DIV) @(negedge clk100);
                if (bus.tx !== 1'b1) mon_ferr++;
                mon_bytes.push_back(b);
                mon_starts.push_back(t0);
            end
        end
    end

    logic [ADDR_W-1:0] ad_prev = '0;
    logic [ADDR_W-1:0] ad_q[$];
    always @(negedge clk100) begin
        if (bus.mem_ad !== ad_prev) begin
            ad_q.push_back(bus.mem_ad);
            ad_prev = bus.mem_ad;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int k = 0; k < DEPTH; k++) begin
            case (pat)
                0:       mem[k] = (k == 0) ? 64'h0000_0064_00A5_0003 : 64'h0;
                1:       mem[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
                default: mem[k] = 64'hA5A5_0000_0000_5A00 + 64'(k) * 64'h0001_0203_0405_0607;
            endcase
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk100);
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [15:0] len, input int n, input bit poke, input string name);
        logic [7:0]        exp_q[$];
        logic [ADDR_W-1:0] exp_ad[$];
        logic [ADDR_W-1:0] prev;
        int cs, busy_cnt, done_cnt, done_cyc, frame_len, bad, gap_bad, fall0;

        frame_len = (4 + 8 * n) * BYTE_CYC;
        exp_q.push_back(8'hFA);
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        for (int w = 0; w < n; w++)
            for (int b = 7; b >= 0; b--) exp_q.push_back(mem[w][b*8 +: 8]);
        exp_q.push_back(8'hFF);

        @(negedge clk100);
        mon_bytes.delete();
        mon_starts.delete();
        ad_q.delete();
        mon_ferr = 0;
        prev = bus.mem_ad;
        for (int v = 0; v <= n; v++) begin
            if (ADDR_W'(v) != prev) exp_ad.push_back(ADDR_W'(v));
            prev = ADDR_W'(v);
        end
        bus.data_length = len;
        bus.start       = 1'b1;
        @(negedge clk100);
        bus.start = 1'b0;
        cs = cyc;
        chk({name, " tx_high_after_accept"}, 64'(bus.tx), 64'd1);
        chk({name, " busy_after_accept"}, 64'(bus.busy), 64'd1);

        busy_cnt = 1;
        done_cnt = 0;
        done_cyc = -1;
        for (int k = 1; k <= frame_len + 50 && done_cyc < 0; k++) begin
            @(negedge clk100);
            if (poke && k == 300) begin
                bus.start       = 1'b1;
                bus.data_length = 16'd5;
            end
            if (poke && k == 301) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        chk({name, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk100);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end

        chk({name, " byte_count"}, 64'(mon_bytes.size()), 64'(exp_q.size()));
        bad = -1;
        for (int i = 0; i < mon_bytes.size() && i < exp_q.size() && bad < 0; i++)
            if (mon_bytes[i] !== exp_q[i]) bad = i;
        if (bad >= 0) $display("  %s byte %0d got %02h want %02h", name, bad, mon_bytes[bad], exp_q[bad]);
        chk({name, " first_bad_byte_index"}, 64'(bad), 64'(-1));
        chk({name, " framing_errors"}, 64'(mon_ferr), 64'd0);
        chk({name, " busy_cycles"}, 64'(busy_cnt), 64'(frame_len + 1));
        chk({name, " done_pulses"}, 64'(done_cnt), 64'd1);
        fall0 = (mon_starts.size() > 0) ? mon_starts[0] : -1000;
        chk({name, " start_latency"}, 64'(fall0 - cs), 64'd1);
        chk({name, " header_to_done"}, 64'(done_cyc - fall0), 64'(frame_len));
        gap_bad = 0;
        for (int i = 1; i < mon_starts.size(); i++)
            if (mon_starts[i] - mon_starts[i-1] != BYTE_CYC) gap_bad++;
        chk({name, " byte_spacing_errors"}, 64'(gap_bad), 64'd0);
        chk({name, " mem_ad_steps"}, 64'(ad_q.size()), 64'(exp_ad.size()));
        bad = -1;
        for (int i = 0; i < ad_q.size() && i < exp_ad.size() && bad < 0; i++)
            if (ad_q[i] !== exp_ad[i]) bad = i;
        chk({name, " mem_ad_first_bad_step"}, 64'(bad), 64'(-1));
        chk({name, " idle_after"}, 64'({bus.busy, bus.tx}), 64'b01);
    endtask

    typedef struct {
        logic [15:0] len;
        int          n;
        int          pat;
        bit          poke;
        string       name;
    } vec_t;

    initial begin
        vec_t       vecs[7];
        logic [7:0] golden[12];
        bit         seen;
        int         nb, busy_hi;

        vecs[0] = '{16'd1,    1,  0, 1'b0, "single"};
        vecs[1] = '{16'd0,    0,  1, 1'b0, "empty"};
        vecs[2] = '{16'd3,    3,  1, 1'b0, "multi"};
        vecs[3] = '{16'd2000, 16, 2, 1'b0, "clamp2000"};
        vecs[4] = '{16'd17,   16, 2, 1'b0, "clamp17"};
        vecs[5] = '{16'd16,   16, 1, 1'b0, "full16"};
        vecs[6] = '{16'd2,    2,  2, 1'b1, "midframe_poke"};
        golden  = '{8'hFA, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64,
                    8'h00, 8'hA5, 8'h00, 8'h03, 8'hFF};

        bus.start       = 1'b0;
        bus.data_length = 16'd0;
        fill_mem(0);
        repeat (3) @(negedge clk100);
        chk("reset tx", 64'(bus.tx), 64'd1);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset mem_ad", 64'(bus.mem_ad), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk100);
        chk("idle tx", 64'(bus.tx), 64'd1);

        for (int i = 0; i < 7; i++) begin
            fill_mem(vecs[i].pat);
            run_frame(vecs[i].len, vecs[i].n, vecs[i].poke, vecs[i].name);
            if (i == 0) begin
                nb = -1;
                for (int j = 0; j < 12 && nb < 0; j++)
                    if (j >= mon_bytes.size() || mon_bytes[j] !== golden[j]) nb = j;
                chk("single golden_first_bad_index", 64'(nb), 64'(-1));
            end
        end

        // start on the DONE cycle is dropped
        fill_mem(1);
        bus.data_length = 16'd1;
        bus.start = 1'b1;
        @(negedge clk100);
        bus.start = 1'b0;
        wait_done(12 * BYTE_CYC + 50, seen);
        chk("dc1 done_seen", 64'(seen), 64'd1);
        bus.start = 1'b1;
        @(negedge clk100);
        bus.start = 1'b0;
        nb = mon_bytes.size();
        busy_hi = 0;
        repeat (100) begin
            @(negedge clk100);
            if (bus.busy || !bus.tx) busy_hi++;
        end
        chk("dc1 start_on_done_ignored", 64'(busy_hi), 64'd0);
        chk("dc1 no_extra_bytes", 64'(mon_bytes.size()), 64'(nb));

        // start held over DONE and the next IDLE cycle: taken on the IDLE cycle
        bus.start = 1'b1;
        @(negedge clk100);
        bus.start = 1'b0;
        wait_done(12 * BYTE_CYC + 50, seen);
        chk("dc2 done_seen", 64'(seen), 64'd1);
        mon_bytes.delete();
        bus.start = 1'b1;
        @(negedge clk100);
        chk("dc2 not_taken_in_done", 64'(bus.busy), 64'd0);
        @(negedge clk100);
        bus.start = 1'b0;
        chk("dc2 taken_in_idle", 64'(bus.busy), 64'd1);
        wait_done(12 * BYTE_CYC + 50, seen);
        chk("dc2 second_frame_done", 64'(seen), 64'd1);
        chk("dc2 second_frame_bytes", 64'(mon_bytes.size()), 64'd12);

        // reset while byte 5 (all-zero data) is on the line
        repeat (4) @(negedge clk100);
        mem[0] = 64'h5A00_1234_5678_9ABC;
        mem[1] = 64'h0F0E_0D0C_0B0A_0908;
        bus.data_length = 16'd2;
        bus.start = 1'b1;
        @(negedge clk100);
        bus.start = 1'b0;
        repeat (4 * BYTE_CYC + 3 * DIV + 4) @(negedge clk100);
        chk("rst precond tx_low", 64'(bus.tx), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async tx", 64'(bus.tx), 64'd1);
        chk("rst async busy", 64'(bus.busy), 64'd0);
        chk("rst async mem_ad", 64'(bus.mem_ad), 64'd0);
        repeat (2) @(negedge clk100);
        rst_n = 1'b1;
        repeat (120) @(negedge clk100);
        run_frame(16'd2, 2, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
